// File: rtl/countdown_ctrl.sv
// Loadable down-counting sequencer: Idle -> Count -> Finished -> Idle.
// Optional hold input enabled by COUNTDOWN_CTRL_PAUSE_EN.
module countdown_ctrl #(
  parameter int BITS = 4
) (
  input  logic            in_clk,
  input  logic            in_rst_n,
  input  logic            in_start,
  input  logic [BITS-1:0] in_load,
`ifdef COUNTDOWN_CTRL_PAUSE_EN
  input  logic            in_pause,
`endif
  output logic            out_ready,
  output logic            out_busy,
  output logic            out_done,
  output logic [BITS-1:0] out_ctr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_FIN   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [BITS-1:0] r_ctr;
  logic [BITS-1:0] w_ctr_nxt;
  logic            w_pause;

`ifdef COUNTDOWN_CTRL_PAUSE_EN
  assign w_pause = in_pause;
`else
  assign w_pause = 1'b0;
`endif

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state <= S_IDLE;
      r_ctr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ctr   <= w_ctr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ctr_nxt   = r_ctr;
    unique case (r_state)
      S_IDLE: begin
        if (in_start) begin
          w_ctr_nxt   = in_load;
          w_state_nxt = (in_load != '0) ? S_COUNT : S_FIN;
        end
      end
      S_COUNT: begin
        // A zero count here is illegal; finishing avoids a wrap to all-ones.
        if (!w_pause) begin
          if (r_ctr > BITS'(1)) begin
            w_ctr_nxt = r_ctr - BITS'(1);
          end else begin
            w_ctr_nxt   = '0;
            w_state_nxt = S_FIN;
          end
        end
      end
      S_FIN: begin
        w_ctr_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_ctr_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign out_ready = (r_state == S_IDLE);
  assign out_busy  = (r_state == S_COUNT);
  assign out_done  = (r_state == S_FIN);
  assign out_ctr   = r_ctr;

endmodule
